// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and total-count helpers for the VGA scan generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned COORD_RANGE = 1024;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_pix_enable.sv
// Pixel-rate divider: one pix_ce pulse every CLK_DIV clocks and a 50% duty pixel clock
// that rises mid-pixel.
module vga_pix_enable #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_pix_ce,
  output logic o_vga_clk
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] r_div_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_pix_ce  = (r_div_cnt == DIV_LAST);
  assign o_vga_clk = (r_div_cnt >= DIV_HALF);

endmodule

// File: rtl/vga_scan_generator.sv
// Raster timing source: scan counters, sync/blank decode and blank-gated colour to the DAC.
// Define VGA_RGB_REG_EN to register colour and delay HS/VS/BLANK_N by one pixel period.
module vga_scan_generator
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > COORD_RANGE) begin : g_h_total_check
    $error("H_TOTAL exceeds the 10-bit coordinate range");
  end
  if (V_TOTAL > COORD_RANGE) begin : g_v_total_check
    $error("V_TOTAL exceeds the 10-bit coordinate range");
  end
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_clk_div_check
    $error("CLK_DIV must be even and at least 2");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t V_VBLANK = coord_t'(V_VISIBLE);

  // Sync windows compared at 32 bits so an end bound of exactly 1024 cannot wrap.
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  logic   w_pix_ce;
  coord_t r_hc;
  coord_t r_vc;
  coord_t w_hc_d;
  coord_t w_vc_d;
  logic   w_hs_active;
  logic   w_vs_active;
  logic   w_visible;
  logic   r_hs;
  logic   r_vs;
  logic   r_blank_n;
  logic   r_frame_start;
  rgb_t   w_rgb_in;
  rgb_t   w_rgb_out;

  vga_pix_enable #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_enable (
    .i_clk     (Clk),
    .i_reset   (Reset),
    .o_pix_ce  (w_pix_ce),
    .o_vga_clk (VGA_CLK)
  );

  always_comb begin
    w_hc_d = r_hc;
    w_vc_d = r_vc;
    if (w_pix_ce) begin
      if (r_hc == H_LAST) begin
        w_hc_d = '0;
        w_vc_d = (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
      end else begin
        w_hc_d = r_hc + 1'b1;
      end
    end
  end

  // Decoded from next-state counters so the registered flags line up with DrawX/DrawY.
  always_comb begin
    w_hs_active = (32'(w_hc_d) >= HS_START) && (32'(w_hc_d) < HS_END);
    w_vs_active = (32'(w_vc_d) >= VS_START) && (32'(w_vc_d) < VS_END);
    w_visible   = (32'(w_hc_d) < H_VISIBLE) && (32'(w_vc_d) < V_VISIBLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hc          <= w_hc_d;
      r_vc          <= w_vc_d;
      r_hs          <= ~w_hs_active;
      r_vs          <= ~w_vs_active;
      r_blank_n     <= w_visible;
      r_frame_start <= w_pix_ce && (w_hc_d == '0) && (w_vc_d == V_VBLANK);
    end
  end

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign frame_start = r_frame_start;
  assign VGA_SYNC_N  = 1'b0;
  assign w_rgb_in    = '{r: Red, g: Green, b: Blue};

`ifdef VGA_RGB_REG_EN
  rgb_t r_rgb;
  logic r_hs_dly;
  logic r_vs_dly;
  logic r_blank_n_dly;

  // Colour for the pixel just finished is captured as the counters step, so every pin is
  // one pixel period behind DrawX/DrawY but mutually aligned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rgb         <= '0;
      r_hs_dly      <= 1'b1;
      r_vs_dly      <= 1'b1;
      r_blank_n_dly <= 1'b0;
    end else if (w_pix_ce) begin
      r_rgb         <= w_rgb_in;
      r_hs_dly      <= r_hs;
      r_vs_dly      <= r_vs;
      r_blank_n_dly <= r_blank_n;
    end
  end

  assign VGA_HS      = r_hs_dly;
  assign VGA_VS      = r_vs_dly;
  assign VGA_BLANK_N = r_blank_n_dly;
  assign w_rgb_out   = r_blank_n_dly ? r_rgb : '0;
`else
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign w_rgb_out   = r_blank_n ? w_rgb_in : '0;
`endif

  assign VGA_R = w_rgb_out.r;
  assign VGA_G = w_rgb_out.g;
  assign VGA_B = w_rgb_out.b;

endmodule
